// File: rtl/decoder2to4_hold_if.sv
// Code-in handshake between the 4-to-2 encoder side and the hold decoder.
// b0 carries code weight 2, b1 carries code weight 1.
interface decoder2to4_hold_if;
    logic in_valid;
    logic in_ready;
    logic b0;
    logic b1;

    modport master (
        output in_valid,
        output b0,
        output b1,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  b0,
        input  b1,
        output in_ready
    );
endinterface

// File: rtl/decoder2to4_hold.sv
// Registered 2-to-4 decoder: each accepted code becomes a HOLD_CYCLES-wide one-hot
// strobe on d0..d3, with a saturating hit counter per output line.
module decoder2to4_hold #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder2to4_hold_if.slave    in_if,
    input  logic                 clear_cnt,
    output logic                 d0,
    output logic                 d1,
    output logic                 d2,
    output logic                 d3,
    output logic                 busy,
    output logic [CNT_W-1:0]     hit0,
    output logic [CNT_W-1:0]     hit1,
    output logic [CNT_W-1:0]     hit2,
    output logic [CNT_W-1:0]     hit3
);
    localparam int unsigned        HCNT_W    = 8;
    localparam logic [HCNT_W-1:0]  HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HIT_MAX   = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    logic [HCNT_W-1:0] r_hcnt;
    logic [3:0]        r_d;
    logic              r_busy;
    logic              r_alive;
    logic [CNT_W-1:0]  r_hit [4];

    logic              w_last;
    logic              w_in_ready;
    logic              w_accept;
    logic [1:0]        w_code;
    logic [3:0]        w_onehot;

    // r_alive keeps in_ready low in reset and until the first edge afterwards
    assign w_last     = (r_state == ST_HOLD) && (r_hcnt == HCNT_LAST);
    assign w_in_ready = r_alive && ((r_state == ST_IDLE) || w_last);
    assign w_accept   = in_if.in_valid && w_in_ready;
    assign w_code     = {in_if.b0, in_if.b1};
    assign w_onehot   = 4'b0001 << w_code;

    assign in_if.in_ready = w_in_ready;

    // Hold sequencer; an accept on the last hold cycle re-arms without an idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_HOLD;
                        r_hcnt  <= '0;
                        r_d     <= w_onehot;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_last) begin
                        r_hcnt <= r_hcnt + HCNT_W'(1);
                    end else if (w_accept) begin
                        r_hcnt <= '0;
                        r_d    <= w_onehot;
                    end else begin
                        r_state <= ST_IDLE;
                        r_hcnt  <= '0;
                        r_d     <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hcnt  <= '0;
                    r_d     <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-line saturating hit counters; clear beats a coincident accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                r_hit[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (clear_cnt) begin
                    r_hit[n] <= '0;
                end else if (w_accept && (w_code == 2'(n)) && (r_hit[n] != HIT_MAX)) begin
                    r_hit[n] <= r_hit[n] + CNT_W'(1);
                end
            end
        end
    end

    assign d0   = r_d[0];
    assign d1   = r_d[1];
    assign d2   = r_d[2];
    assign d3   = r_d[3];
    assign busy = r_busy;
    assign hit0 = r_hit[0];
    assign hit1 = r_hit[1];
    assign hit2 = r_hit[2];
    assign hit3 = r_hit[3];
endmodule

// File: tb/tb_decoder2to4_hold.sv
// Bench for decoder2to4_hold: three instances (H=4/CNT_W=8, H=4/CNT_W=2, H=1/CNT_W=8)
// checked every cycle against a remaining-cycles reference model, plus directed sequences.
module tb_decoder2to4_hold;
    localparam int NDUT = 3;

    typedef struct {
        bit         vld;
        int         code;
        logic [3:0] exp_d;
        bit         exp_rdy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       vld  [NDUT];
    logic [1:0] code [NDUT];
    logic       clr  [NDUT];
    logic       rdy  [NDUT];
    logic [3:0] dv   [NDUT];
    logic       bsy  [NDUT];
    logic [7:0] hv   [NDUT][4];

    logic       a_d0, a_d1, a_d2, a_d3, a_busy;
    logic [7:0] a_h0, a_h1, a_h2, a_h3;
    logic       b_d0, b_d1, b_d2, b_d3, b_busy;
    logic [1:0] b_h0, b_h1, b_h2, b_h3;
    logic       c_d0, c_d1, c_d2, c_d3, c_busy;
    logic [7:0] c_h0, c_h1, c_h2, c_h3;

    decoder2to4_hold_if ifa ();
    decoder2to4_hold_if ifb ();
    decoder2to4_hold_if ifc ();

    assign ifa.in_valid = vld[0];
    assign ifa.b0 = code[0][1];
    assign ifa.b1 = code[0][0];
    assign ifb.in_valid = vld[1];
    assign ifb.b0 = code[1][1];
    assign ifb.b1 = code[1][0];
    assign ifc.in_valid = vld[2];
    assign ifc.b0 = code[2][1];
    assign ifc.b1 = code[2][0];

    decoder2to4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_if(ifa), .clear_cnt(clr[0]),
        .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3), .busy(a_busy),
        .hit0(a_h0), .hit1(a_h1), .hit2(a_h2), .hit3(a_h3));
    decoder2to4_hold #(.HOLD_CYCLES(4), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_if(ifb), .clear_cnt(clr[1]),
        .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3), .busy(b_busy),
        .hit0(b_h0), .hit1(b_h1), .hit2(b_h2), .hit3(b_h3));
    decoder2to4_hold #(.HOLD_CYCLES(1), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_if(ifc), .clear_cnt(clr[2]),
        .d0(c_d0), .d1(c_d1), .d2(c_d2), .d3(c_d3), .busy(c_busy),
        .hit0(c_h0), .hit1(c_h1), .hit2(c_h2), .hit3(c_h3));

    assign rdy[0] = ifa.in_ready;
    assign rdy[1] = ifb.in_ready;
    assign rdy[2] = ifc.in_ready;
    assign dv[0]  = {a_d3, a_d2, a_d1, a_d0};
    assign dv[1]  = {b_d3, b_d2, b_d1, b_d0};
    assign dv[2]  = {c_d3, c_d2, c_d1, c_d0};
    assign bsy[0] = a_busy;
    assign bsy[1] = b_busy;
    assign bsy[2] = c_busy;
    assign hv[0][0] = a_h0;
    assign hv[0][1] = a_h1;
    assign hv[0][2] = a_h2;
    assign hv[0][3] = a_h3;
    assign hv[1][0] = {6'd0, b_h0};
    assign hv[1][1] = {6'd0, b_h1};
    assign hv[1][2] = {6'd0, b_h2};
    assign hv[1][3] = {6'd0, b_h3};
    assign hv[2][0] = c_h0;
    assign hv[2][1] = c_h1;
    assign hv[2][2] = c_h2;
    assign hv[2][3] = c_h3;

    // Reference model: cycles of strobe remaining, current code, hit tallies
    int unsigned hold_of [NDUT] = '{4, 4, 1};
    int unsigned max_of  [NDUT] = '{255, 3, 255};
    int  rem   [NDUT];
    int  mcode [NDUT];
    int  mhit  [NDUT][4];
    bit  alive;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        alive = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            rem[i] = 0;
            mcode[i] = 0;
            for (int n = 0; n < 4; n++) mhit[i][n] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ed;
        for (int i = 0; i < NDUT; i++) begin
            ed = (rem[i] > 0) ? 4'(1 << mcode[i]) : 4'd0;
            chk($sformatf("%s/dut%0d/d", tag, i), 32'(dv[i]), 32'(ed));
            chk($sformatf("%s/dut%0d/busy", tag, i), 32'(bsy[i]), 32'(rem[i] > 0));
            chk($sformatf("%s/dut%0d/in_ready", tag, i), 32'(rdy[i]), 32'(alive && rem[i] <= 1));
            for (int n = 0; n < 4; n++)
                chk($sformatf("%s/dut%0d/hit%0d", tag, i, n), 32'(hv[i][n]), 32'(mhit[i][n]));
        end
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < NDUT; i++) begin
                acc = vld[i] && alive && (rem[i] <= 1);
                if (clr[i]) begin
                    for (int n = 0; n < 4; n++) mhit[i][n] = 0;
                end else if (acc && mhit[i][code[i]] < int'(max_of[i])) begin
                    mhit[i][code[i]]++;
                end
                if (acc) begin
                    rem[i] = int'(hold_of[i]);
                    mcode[i] = int'(code[i]);
                end else if (rem[i] > 0) begin
                    rem[i]--;
                end
            end
            alive = 1'b1;
        end
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic wait_ready(input int i);
        int guard = 0;
        while (!(alive && rem[i] <= 1) && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("wait_ready_timeout", 32'(guard), 32'(0));
    endtask

    task automatic send(input int i, input int c, input bit cl);
        wait_ready(i);
        vld[i] = 1'b1;
        code[i] = 2'(c);
        clr[i] = cl;
        tick();
        vld[i] = 1'b0;
        clr[i] = 1'b0;
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NDUT; i++) begin
            vld[i] = 1'b0;
            code[i] = 2'd0;
            clr[i] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset_release");
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t tbl [18];
    logic [15:0] d_mask, r_mask, o_mask;

    initial begin
        // Mapping table for the H=4 instance: codes 0..3 back-to-back
        tbl[0] = '{vld: 1'b1, code: 0, exp_d: 4'b0000, exp_rdy: 1'b1};
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                tbl[1 + 4*k + j] = '{vld: (j == 3 && k < 3), code: k + 1,
                                     exp_d: 4'(1 << k), exp_rdy: (j == 3)};
        tbl[17] = '{vld: 1'b0, code: 0, exp_d: 4'b0000, exp_rdy: 1'b1};

        apply_reset();

        for (int r = 0; r < 18; r++) begin
            chk($sformatf("map[%0d]/d", r), 32'(dv[0]), 32'(tbl[r].exp_d));
            chk($sformatf("map[%0d]/in_ready", r), 32'(rdy[0]), 32'(tbl[r].exp_rdy));
            chk($sformatf("map[%0d]/onehot", r), 32'($countones(dv[0]) <= 1), 32'(1));
            vld[0] = tbl[r].vld;
            code[0] = 2'(tbl[r].code);
            tick();
        end
        vld[0] = 1'b0;
        for (int n = 0; n < 4; n++)
            chk($sformatf("map/hit%0d", n), 32'(hv[0][n]), 32'(1));

        // Back-to-back: code 2 held valid through three accepts
        d_mask = '0;
        r_mask = '0;
        vld[0] = 1'b1;
        code[0] = 2'd2;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (dv[0][2]) d_mask[c] = 1'b1;
            if (dv[0][2] && rdy[0]) r_mask[c] = 1'b1;
            if (c == 9) vld[0] = 1'b0;
        end
        chk("b2b/d2_cycles", 32'(d_mask), 32'(16'h1FFE));
        chk("b2b/ready_pulses", 32'(r_mask), 32'(16'h1110));
        chk("b2b/hit2", 32'(hv[0][2]), 32'(4));

        // Request during a busy strobe is dropped
        d_mask = '0;
        o_mask = '0;
        send(0, 1, 1'b0);
        if (dv[0][1]) d_mask[1] = 1'b1;
        tick();
        if (dv[0][1]) d_mask[2] = 1'b1;
        vld[0] = 1'b1;
        code[0] = 2'd3;
        for (int c = 3; c <= 8; c++) begin
            tick();
            vld[0] = 1'b0;
            if (dv[0][1]) d_mask[c] = 1'b1;
            if (dv[0][3]) o_mask[c] = 1'b1;
        end
        chk("ignore/d1_cycles", 32'(d_mask), 32'(16'h001E));
        chk("ignore/d3_never", 32'(o_mask), 32'(0));
        chk("ignore/hit3", 32'(hv[0][3]), 32'(1));
        chk("ignore/hit1", 32'(hv[0][1]), 32'(2));

        // Saturation and clear on the 2-bit-counter instance
        for (int n = 1; n <= 5; n++) begin
            send(1, 0, 1'b0);
            chk($sformatf("sat/hit0_after_%0d", n), 32'(hv[1][0]), 32'((n < 3) ? n : 3));
        end
        send(1, 0, 1'b1);
        chk("clear/hit0", 32'(hv[1][0]), 32'(0));
        chk("clear/d0_strobes", 32'(dv[1][0]), 32'(1));
        repeat (5) tick();

        // Asynchronous reset in the middle of a d3 strobe
        send(0, 3, 1'b0);
        tick();
        chk("arst/d3_before", 32'(dv[0][3]), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst/d3_now", 32'(dv[0][3]), 32'(0));
        chk("arst/hit3_now", 32'(hv[0][3]), 32'(0));
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        check_all("arst_release");
        tick();
        chk("arst/ready_after", 32'(rdy[0]), 32'(1));
        send(0, 2, 1'b0);
        chk("arst/next_code", 32'(dv[0]), 32'(4'b0100));
        repeat (4) tick();

        // HOLD_CYCLES=1: stream 0,3,1 on consecutive cycles
        vld[2] = 1'b1;
        code[2] = 2'd0;
        tick();
        chk("h1/d_code0", 32'(dv[2]), 32'(4'b0001));
        chk("h1/ready0", 32'(rdy[2]), 32'(1));
        code[2] = 2'd3;
        tick();
        chk("h1/d_code3", 32'(dv[2]), 32'(4'b1000));
        chk("h1/ready1", 32'(rdy[2]), 32'(1));
        code[2] = 2'd1;
        tick();
        chk("h1/d_code1", 32'(dv[2]), 32'(4'b0010));
        chk("h1/ready2", 32'(rdy[2]), 32'(1));
        vld[2] = 1'b0;
        tick();
        chk("h1/d_idle", 32'(dv[2]), 32'(0));

        // Randomized traffic on all instances
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NDUT; i++) begin
                vld[i] = 1'($urandom_range(0, 1));
                code[i] = 2'($urandom_range(0, 3));
                clr[i] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        for (int i = 0; i < NDUT; i++) begin
            vld[i] = 1'b0;
            clr[i] = 1'b0;
        end
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
